// File: rtl/line_window_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a 3x3 tap register, one centred window per pixel.
// Border taps are zero-padded; define WIN_REPLICATE_EN to replicate the nearest in-frame pixel instead.
module line_window_3x3 #(
    parameter int WIDTH       = 320,
    parameter int HEIGHT      = 240,
    parameter int PIXEL_WIDTH = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PIXEL_WIDTH-1:0]     in_pixel,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [9*PIXEL_WIDTH-1:0]   neighborhood,
    output logic [$clog2(WIDTH)-1:0]   out_x,
    output logic [$clog2(HEIGHT)-1:0]  out_y,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       frame_done
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int FW = $clog2(WIDTH + 1);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [FW-1:0] F_LAST = FW'(WIDTH);

`ifdef WIN_REPLICATE_EN
    localparam bit REPLICATE = 1'b1;
`else
    localparam bit REPLICATE = 1'b0;
`endif

    typedef enum logic {STREAM = 1'b0, FLUSH = 1'b1} state_t;
    typedef logic [PIXEL_WIDTH-1:0] pix_t;
    typedef logic [8:0][PIXEL_WIDTH-1:0] taps_t;

    // Handshake: a pixel moves when in_valid && in_ready, a window moves when out_valid && out_ready;
    // a valid window holds every output stable until it is taken, and nothing advances while it waits.

    state_t           state_q, state_d;
    logic             run_q;
    logic [XW-1:0]    in_x_q, in_x_d;
    logic [YW-1:0]    in_y_q, in_y_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic [XW-1:0]    cx_q, cx_d;
    logic [YW-1:0]    cy_q, cy_d;
    logic [XW-1:0]    out_x_q, out_x_d;
    logic [YW-1:0]    out_y_q, out_y_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             frame_done_q, frame_done_d;
    taps_t            tap_q, tap_d;
    taps_t            win;
    pix_t             rd1_q, rd2_q;
    pix_t             line1_mem [WIDTH];
    pix_t             line2_mem [WIDTH];

    logic             out_free;
    logic             accept;
    logic             inject;
    logic             advance;
    logic             win_gen;
    pix_t             shift_pix;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STREAM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            STREAM: if (accept && in_x_q == X_LAST && in_y_q == Y_LAST) state_d = FLUSH;
            FLUSH:  if (inject && fcnt_q == F_LAST) state_d = STREAM;
            default: state_d = STREAM;
        endcase
    end

    // Output logic of the state machine
    always_comb begin
        out_free  = !out_valid_q || out_ready;
        in_ready  = run_q && (state_q == STREAM) && out_free;
        accept    = in_valid && in_ready;
        inject    = (state_q == FLUSH) && out_free;
        advance   = accept || inject;
        shift_pix = accept ? in_pixel : '0;
        // The first window appears once pixel WIDTH+1 arrives; every flush step yields one.
        win_gen   = inject ||
                    (accept && ((in_y_q > Y_ONE) || (in_y_q == Y_ONE && in_x_q != '0)));
    end

    // Input raster position and flush counter
    always_comb begin
        in_x_d = in_x_q;
        in_y_d = in_y_q;
        fcnt_d = fcnt_q;
        if (accept) begin
            fcnt_d = '0;
            if (in_x_q == X_LAST) begin
                in_x_d = '0;
                in_y_d = (in_y_q == Y_LAST) ? '0 : in_y_q + 1'b1;
            end else begin
                in_x_d = in_x_q + 1'b1;
            end
        end else if (inject) begin
            if (fcnt_q == F_LAST) begin
                in_x_d = '0;
                in_y_d = '0;
                fcnt_d = '0;
            end else begin
                in_x_d = (in_x_q == X_LAST) ? '0 : in_x_q + 1'b1;
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Tap register: column 2 takes {line2[x], line1[x], pixel}, older columns slide left
    always_comb begin
        tap_d = tap_q;
        if (advance) begin
            tap_d[0] = tap_q[1];
            tap_d[1] = tap_q[2];
            tap_d[2] = rd2_q;
            tap_d[3] = tap_q[4];
            tap_d[4] = tap_q[5];
            tap_d[5] = rd1_q;
            tap_d[6] = tap_q[7];
            tap_d[7] = tap_q[8];
            tap_d[8] = shift_pix;
        end
    end

    // Output window bookkeeping
    always_comb begin
        cx_d         = cx_q;
        cy_d         = cy_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        frame_done_d = out_valid_q && out_ready && out_last_q;
        if (win_gen) begin
            out_valid_d = 1'b1;
            out_x_d     = cx_q;
            out_y_d     = cy_q;
            out_last_d  = (cx_q == X_LAST) && (cy_q == Y_LAST);
            if (cx_q == X_LAST) begin
                cx_d = '0;
                cy_d = (cy_q == Y_LAST) ? '0 : cy_q + 1'b1;
            end else begin
                cx_d = cx_q + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q        <= 1'b0;
            in_x_q       <= '0;
            in_y_q       <= '0;
            fcnt_q       <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            tap_q        <= '0;
        end else begin
            run_q        <= 1'b1;
            in_x_q       <= in_x_d;
            in_y_q       <= in_y_d;
            fcnt_q       <= fcnt_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            tap_q        <= tap_d;
        end
    end

    // Line buffers: read address is the next x, so the data is waiting when that pixel arrives
    always_ff @(posedge clk) begin
        if (advance) begin
            line1_mem[in_x_q] <= shift_pix;
            line2_mem[in_x_q] <= rd1_q;
        end
        rd1_q <= line1_mem[in_x_d];
        rd2_q <= line2_mem[in_x_d];
    end

    // Border handling: columns first, then rows, so corners combine both rules
    always_comb begin
        win = tap_q;
        if (out_x_q == '0) begin
            win[0] = REPLICATE ? win[1] : '0;
            win[3] = REPLICATE ? win[4] : '0;
            win[6] = REPLICATE ? win[7] : '0;
        end
        if (out_x_q == X_LAST) begin
            win[2] = REPLICATE ? win[1] : '0;
            win[5] = REPLICATE ? win[4] : '0;
            win[8] = REPLICATE ? win[7] : '0;
        end
        if (out_y_q == '0) begin
            win[0] = REPLICATE ? win[3] : '0;
            win[1] = REPLICATE ? win[4] : '0;
            win[2] = REPLICATE ? win[5] : '0;
        end
        if (out_y_q == Y_LAST) begin
            win[6] = REPLICATE ? win[3] : '0;
            win[7] = REPLICATE ? win[4] : '0;
            win[8] = REPLICATE ? win[5] : '0;
        end
    end

    assign neighborhood = win;
    assign out_x        = out_x_q;
    assign out_y        = out_y_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_line_window_3x3.sv
// Directed bench for line_window_3x3 on a 4x3 frame of pixels 1..12; expected windows are a hand-written table.
// Build with WIN_REPLICATE_EN defined to check the replicate-padding table instead of the zero-padding one.
module tb_line_window_3x3;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int PW = 8;
    localparam int NW = W * H;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [PW-1:0]     in_pixel = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [9*PW-1:0]   neighborhood;
    logic [1:0]        out_x;
    logic [1:0]        out_y;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_last;
    logic              frame_done;

    line_window_3x3 #(.WIDTH(W), .HEIGHT(H), .PIXEL_WIDTH(PW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_pixel     (in_pixel),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .neighborhood (neighborhood),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .frame_done   (frame_done)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0]      x;
        logic [1:0]      y;
        logic            last;
        logic [9*PW-1:0] nb;
    } win_t;

    win_t tab [NW];
    win_t exp_q [$];

    int checks = 0;
    int failures = 0;
    int taken = 0;
    int stall_at = 0;
    int stall_cnt = 0;
    int fv_cyc = -1;
    int acc6_cyc = 0;
    int last_cnt = 0;
    int fd_cnt = 0;
    bit fd_exp = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [9*PW-1:0] mk(input int t0, t1, t2, t3, t4, t5, t6, t7, t8);
        return {PW'(t8), PW'(t7), PW'(t6), PW'(t5), PW'(t4), PW'(t3), PW'(t2), PW'(t1), PW'(t0)};
    endfunction

    task automatic set_win(input int i, input logic [9*PW-1:0] nb);
        tab[i].x    = 2'(i % W);
        tab[i].y    = 2'(i / W);
        tab[i].last = (i == NW - 1);
        tab[i].nb   = nb;
    endtask

    task automatic load_table();
`ifdef WIN_REPLICATE_EN
        set_win(0,  mk(1, 1, 2,   1, 1, 2,   5, 5, 6));
        set_win(1,  mk(1, 2, 3,   1, 2, 3,   5, 6, 7));
        set_win(2,  mk(2, 3, 4,   2, 3, 4,   6, 7, 8));
        set_win(3,  mk(3, 4, 4,   3, 4, 4,   7, 8, 8));
        set_win(4,  mk(1, 1, 2,   5, 5, 6,   9, 9, 10));
        set_win(5,  mk(1, 2, 3,   5, 6, 7,   9, 10, 11));
        set_win(6,  mk(2, 3, 4,   6, 7, 8,   10, 11, 12));
        set_win(7,  mk(3, 4, 4,   7, 8, 8,   11, 12, 12));
        set_win(8,  mk(5, 5, 6,   9, 9, 10,  9, 9, 10));
        set_win(9,  mk(5, 6, 7,   9, 10, 11, 9, 10, 11));
        set_win(10, mk(6, 7, 8,   10, 11, 12, 10, 11, 12));
        set_win(11, mk(7, 8, 8,   11, 12, 12, 11, 12, 12));
`else
        set_win(0,  mk(0, 0, 0,   0, 1, 2,   0, 5, 6));
        set_win(1,  mk(0, 0, 0,   1, 2, 3,   5, 6, 7));
        set_win(2,  mk(0, 0, 0,   2, 3, 4,   6, 7, 8));
        set_win(3,  mk(0, 0, 0,   3, 4, 0,   7, 8, 0));
        set_win(4,  mk(0, 1, 2,   0, 5, 6,   0, 9, 10));
        set_win(5,  mk(1, 2, 3,   5, 6, 7,   9, 10, 11));
        set_win(6,  mk(2, 3, 4,   6, 7, 8,   10, 11, 12));
        set_win(7,  mk(3, 4, 0,   7, 8, 0,   11, 12, 0));
        set_win(8,  mk(0, 5, 6,   0, 9, 10,  0, 0, 0));
        set_win(9,  mk(5, 6, 7,   9, 10, 11, 0, 0, 0));
        set_win(10, mk(6, 7, 8,   10, 11, 12, 0, 0, 0));
        set_win(11, mk(7, 8, 0,   11, 12, 0, 0, 0, 0));
`endif
    endtask

    // Scoreboard: compares every taken window against the expected queue
    initial begin
        win_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fd_exp = 1'b0;
            end else begin
                if (fd_exp || frame_done) begin
                    chk("frame_done", frame_done, fd_exp);
                    if (frame_done) fd_cnt++;
                end
                fd_exp = 1'b0;
                if (out_valid && fv_cyc < 0) fv_cyc = cyc;
                if (out_valid && !out_ready) begin
                    if (exp_q.size() > 0) chk("held_window", neighborhood, exp_q[0].nb);
                    chk("stall_in_ready", in_ready, 1'b0);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_window: got x=%0d y=%0d expected no window", out_x, out_y);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("win_x%0d_y%0d_nb", e.x, e.y), neighborhood, e.nb);
                        chk($sformatf("win_x%0d_y%0d_out_x", e.x, e.y), out_x, e.x);
                        chk($sformatf("win_x%0d_y%0d_out_y", e.x, e.y), out_y, e.y);
                        chk($sformatf("win_x%0d_y%0d_last", e.x, e.y), out_last, e.last);
                        if (e.last) begin
                            last_cnt++;
                            fd_exp = 1'b1;
                        end
                    end
                    taken++;
                    if (taken == stall_at) stall_cnt = 5;
                end
            end
        end
    end

    // Consumer: out_ready is high except during a requested stall
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_cnt > 0) begin
                out_ready = 1'b0;
                stall_cnt--;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic send_pixel(input logic [PW-1:0] v, output int waited);
        waited = 0;
        in_valid = 1'b1;
        in_pixel = v;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit keep, input int npix, output int first_wait);
        int w;
        first_wait = 0;
        for (int i = 0; i < npix; i++) begin
            send_pixel(PW'(i + 1), w);
            if (i == 0) first_wait = w;
            if (i == 5) acc6_cyc = cyc;
        end
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic push_frame();
        for (int i = 0; i < NW; i++) exp_q.push_back(tab[i]);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain_left"}, exp_q.size(), 0);
        repeat (3) @(negedge clk);
        chk({name, "_idle_out_valid"}, out_valid, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic start_test(input int stall);
        taken = 0;
        stall_at = stall;
        fv_cyc = -1;
        last_cnt = 0;
        fd_cnt = 0;
    endtask

    task automatic check_reset_state(input string name);
        chk({name, "_out_valid"}, out_valid, 1'b0);
        chk({name, "_in_ready"}, in_ready, 1'b0);
        chk({name, "_out_last"}, out_last, 1'b0);
        chk({name, "_frame_done"}, frame_done, 1'b0);
        chk({name, "_neighborhood"}, neighborhood, '0);
        chk({name, "_out_x"}, out_x, 2'd0);
        chk({name, "_out_y"}, out_y, 2'd0);
    endtask

    initial begin
        int w;
        load_table();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: free-flowing frame
        start_test(0);
        push_frame();
        send_frame(1'b0, NW, w);
        wait_drain("t1");
        chk("t1_first_valid_cycle", fv_cyc, acc6_cyc);
        chk("t1_windows", taken, NW);
        chk("t1_last_count", last_cnt, 1);
        chk("t1_frame_done_count", fd_cnt, 1);

        // Test 2: consumer stalls 5 cycles after the third window
        start_test(3);
        push_frame();
        send_frame(1'b0, NW, w);
        wait_drain("t2");
        chk("t2_windows", taken, NW);
        chk("t2_last_count", last_cnt, 1);
        chk("t2_frame_done_count", fd_cnt, 1);

        // Test 4: two frames back to back with in_valid held high
        start_test(0);
        push_frame();
        push_frame();
        send_frame(1'b1, NW, w);
        send_frame(1'b0, NW, w);
        chk("t4_flush_wait_cycles", w, W + 1);
        wait_drain("t4");
        chk("t4_windows", taken, 2 * NW);
        chk("t4_last_count", last_cnt, 2);
        chk("t4_frame_done_count", fd_cnt, 2);

        // Test 5: reset after 7 pixels, then a clean frame
        start_test(0);
        push_frame();
        send_frame(1'b1, 7, w);
        rst_n = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        chk("t5_reset_out_valid", out_valid, 1'b0);
        chk("t5_reset_in_ready", in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("t5_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_test(0);
        push_frame();
        send_frame(1'b0, NW, w);
        wait_drain("t5");
        chk("t5_first_valid_cycle", fv_cyc, acc6_cyc);
        chk("t5_windows", taken, NW);
        chk("t5_last_count", last_cnt, 1);
        chk("t5_frame_done_count", fd_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends with a summary
    initial begin
        #200000;
        checks++;
        failures++;
        $display("FAIL global_timeout: got no finish expected finish before 200000 time units");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
